// File: rtl/rv32i_amo_sequencer_pkg.sv
// Shared constants and state type for the RV32A word-atomic sequencer.
package rv32i_amo_sequencer_pkg;

  localparam logic [4:0] AMO_F5_ADD  = 5'b00000;
  localparam logic [4:0] AMO_F5_SWAP = 5'b00001;
  localparam logic [4:0] AMO_F5_XOR  = 5'b00100;
  localparam logic [4:0] AMO_F5_OR   = 5'b01000;
  localparam logic [4:0] AMO_F5_AND  = 5'b01100;

  localparam logic [2:0] AMO_F3_W    = 3'b010;

  typedef enum logic [2:0] {
    AMO_ST_IDLE,
    AMO_ST_RD_REQ,
    AMO_ST_RD_WAIT,
    AMO_ST_WR_REQ,
    AMO_ST_DONE
  } amo_state_t;

endpackage

// File: rtl/rv32i_amo_sequencer_alu.sv
// Combinational AMO operation unit; also flags funct5 codes outside the supported set.
module rv32i_amo_alu
  import rv32i_amo_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [4:0]      funct5,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic [XLEN-1:0] new_val,
  output logic            unsupported
);

  always_comb begin
    new_val     = '0;
    unsupported = 1'b0;
    case (funct5)
      AMO_F5_ADD:  new_val = old_val + rs2_val;
      AMO_F5_SWAP: new_val = rs2_val;
      AMO_F5_XOR:  new_val = old_val ^ rs2_val;
      AMO_F5_OR:   new_val = old_val | rs2_val;
      AMO_F5_AND:  new_val = old_val & rs2_val;
      default:     unsupported = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_amo_sequencer.sv
// Read-modify-write sequencer for RV32A word atomics: stalls the core, reads,
// computes, writes back to memory and returns the old value for write-back.
module rv32i_amo_sequencer
  import rv32i_amo_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            amo_start,
  input  logic [4:0]      amo_funct5,
  input  logic [2:0]      amo_funct3,
  input  logic [XLEN-1:0] amo_addr,
  input  logic [XLEN-1:0] amo_rs2,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rd_we,
  output logic [XLEN-1:0] rd_data,
  output logic            amo_done,
  output logic            amo_fault
);

  amo_state_t      state, state_nx;
  logic [XLEN-1:0] addr_q, rs2_q, old_q, new_q;
  logic [4:0]      funct5_q;
  logic            fault_q;

  logic [4:0]      alu_funct5;
  logic [XLEN-1:0] alu_new;
  logic            alu_unsupported;
  logic            start_fault;

  // One ALU serves both the IDLE legality check (live funct5) and the RD_WAIT compute.
  assign alu_funct5 = (state == AMO_ST_IDLE) ? amo_funct5 : funct5_q;

  rv32i_amo_alu #(.XLEN(XLEN)) u_alu (
    .funct5      (alu_funct5),
    .old_val     (mem_rdata),
    .rs2_val     (rs2_q),
    .new_val     (alu_new),
    .unsupported (alu_unsupported)
  );

  assign start_fault = (amo_addr[1:0] != 2'b00) || (amo_funct3 != AMO_F3_W) || alu_unsupported;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= AMO_ST_IDLE;
      addr_q   <= '0;
      rs2_q    <= '0;
      funct5_q <= '0;
      old_q    <= '0;
      new_q    <= '0;
      fault_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == AMO_ST_IDLE && amo_start) begin
        addr_q   <= amo_addr;
        rs2_q    <= amo_rs2;
        funct5_q <= amo_funct5;
        fault_q  <= start_fault;
        old_q    <= '0;
      end
      if (state == AMO_ST_RD_WAIT && mem_rvalid) begin
        old_q <= mem_rdata;
        new_q <= alu_new;
      end
    end
  end

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    case (state)
      AMO_ST_IDLE: begin
        if (amo_start) begin
          stall    = 1'b1;
          state_nx = start_fault ? AMO_ST_DONE : AMO_ST_RD_REQ;
        end
      end
      AMO_ST_RD_REQ: begin
        stall = 1'b1;
        if (mem_gnt) state_nx = AMO_ST_RD_WAIT;
      end
      AMO_ST_RD_WAIT: begin
        stall = 1'b1;
        if (mem_rvalid) state_nx = AMO_ST_WR_REQ;
      end
      AMO_ST_WR_REQ: begin
        stall = 1'b1;
        if (mem_gnt) state_nx = AMO_ST_DONE;
      end
      AMO_ST_DONE: state_nx = AMO_ST_IDLE;
      default:     state_nx = AMO_ST_IDLE;
    endcase
  end

  assign mem_req   = (state == AMO_ST_RD_REQ) || (state == AMO_ST_WR_REQ);
  assign mem_we    = (state == AMO_ST_WR_REQ);
  assign mem_addr  = addr_q;
  assign mem_wdata = new_q;
  assign amo_done  = (state == AMO_ST_DONE);
  assign amo_fault = amo_done && fault_q;
  assign rd_we     = amo_done && !fault_q;
  assign rd_data   = old_q;

endmodule

// File: tb/tb_rv32i_amo_sequencer.sv
// Scoreboard bench for rv32i_amo_sequencer with a behavioural memory responder.
module tb_rv32i_amo_sequencer;
  import rv32i_amo_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        amo_start;
  logic [4:0]  amo_funct5;
  logic [2:0]  amo_funct3;
  logic [31:0] amo_addr, amo_rs2;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rd_we;
  logic [31:0] rd_data;
  logic        amo_done, amo_fault;

  rv32i_amo_sequencer #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .amo_start  (amo_start),
    .amo_funct5 (amo_funct5),
    .amo_funct3 (amo_funct3),
    .amo_addr   (amo_addr),
    .amo_rs2    (amo_rs2),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rd_we      (rd_we),
    .rd_data    (rd_data),
    .amo_done   (amo_done),
    .amo_fault  (amo_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd_we;
    logic [31:0] rd_data;
    logic        fault;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [31:0] mem [0:1023];
  int          rd_delay = 0, wr_delay = 0, rv_lat = 1;
  int          wait_cnt = 0, rv_cnt = 0;
  logic [9:0]  rv_idx = '0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic        req_seen = 1'b0;
  int          wr_count = 0, rdwe_count = 0, done_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory responder: grants after a programmable wait, read data a fixed latency after grant.
  initial begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_gnt    = 1'b0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem[rv_idx];
        end
      end
      if (mem_req) begin
        req_seen = 1'b1;
        check("mem_addr", mem_addr, exp_addr);
        if (mem_we) check("mem_wdata", mem_wdata, exp_wdata);
        if (wait_cnt < (mem_we ? wr_delay : rd_delay)) begin
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          mem_gnt  = 1'b1;
          if (mem_we) begin
            mem[mem_addr[11:2]] = mem_wdata;
            wr_count++;
          end else begin
            rv_cnt = rv_lat;
            rv_idx = mem_addr[11:2];
          end
        end
      end
    end
  end

  // Scoreboard monitor: pops one expectation per completion pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_we) rdwe_count++;
      if (amo_done) begin
        done_count++;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got amo_done=1 expected no completion");
        end else begin
          e = sb_q.pop_front();
          check("amo_fault", 32'(amo_fault), 32'(e.fault));
          check("rd_we", 32'(rd_we), 32'(e.rd_we));
          if (e.rd_we) check("rd_data", rd_data, e.rd_data);
        end
      end else if (rd_we) begin
        n_checks++;
        n_fail++;
        $display("FAIL stray_rd_we: got rd_we=1 expected 0 outside DONE");
      end
    end
  end

  task automatic run_amo(input string name, input logic [4:0] f5, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] mem_init, input logic exp_fault,
                         input logic [31:0] exp_new, input int exp_lat, input int exp_stall);
    exp_t e;
    int   cyc, stalls;
    bit   fin;
    if (!exp_fault) mem[addr[11:2]] = mem_init;
    exp_addr  = addr;
    exp_wdata = exp_new;
    req_seen  = 1'b0;
    wait_cnt  = 0;
    e.rd_we   = !exp_fault;
    e.rd_data = mem_init;
    e.fault   = exp_fault;
    sb_q.push_back(e);
    @(negedge clk);
    amo_start  = 1'b1;
    amo_funct5 = f5;
    amo_funct3 = f3;
    amo_addr   = addr;
    amo_rs2    = rs2;
    cyc = 0; stalls = 0; fin = 0;
    while (!fin) begin
      #1;
      cyc++;
      if (stall) stalls++;
      if (amo_done) fin = 1;
      else if (cyc >= 40) begin
        fin = 1;
        n_checks++;
        n_fail++;
        $display("FAIL %s_timeout: got no amo_done after %0d cycles expected %0d", name, cyc, exp_lat);
      end else @(negedge clk);
    end
    amo_start = 1'b0;
    check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    if (exp_fault) check({name, "_no_mem_req"}, 32'(req_seen), 32'd0);
    else           check({name, "_mem_after"}, mem[addr[11:2]], exp_new);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_stall"},     32'(stall),     32'd0);
    check({name, "_mem_req"},   32'(mem_req),   32'd0);
    check({name, "_mem_we"},    32'(mem_we),    32'd0);
    check({name, "_rd_we"},     32'(rd_we),     32'd0);
    check({name, "_amo_done"},  32'(amo_done),  32'd0);
    check({name, "_amo_fault"}, 32'(amo_fault), 32'd0);
    check({name, "_mem_addr"},  mem_addr,  32'd0);
    check({name, "_mem_wdata"}, mem_wdata, 32'd0);
    check({name, "_rd_data"},   rd_data,   32'd0);
  endtask

  initial begin
    int base_wr, base_rdwe, base_done;
    rst        = 1'b1;
    amo_start  = 1'b0;
    amo_funct5 = '0;
    amo_funct3 = '0;
    amo_addr   = '0;
    amo_rs2    = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    rd_delay = 0; wr_delay = 0; rv_lat = 1;
    run_amo("add_basic", AMO_F5_ADD, 3'b010, 32'h100, 32'd3, 32'd5, 1'b0, 32'd8, 5, 4);

    rd_delay = 2; wr_delay = 3;
    run_amo("swap_wait", AMO_F5_SWAP, 3'b010, 32'h104, 32'hCAFEBABE, 32'h12345678,
            1'b0, 32'hCAFEBABE, 10, 9);

    rd_delay = 0; wr_delay = 0;
    run_amo("add_wrap", AMO_F5_ADD, 3'b010, 32'h108, 32'd1, 32'hFFFFFFFF, 1'b0, 32'h0, 5, 4);
    run_amo("and", AMO_F5_AND, 3'b010, 32'h10C, 32'hFF00FF00, 32'hF0F0F0F0, 1'b0, 32'hF000F000, 5, 4);
    run_amo("or",  AMO_F5_OR,  3'b010, 32'h110, 32'hFF00FF00, 32'hF0F0F0F0, 1'b0, 32'hFFF0FFF0, 5, 4);
    run_amo("xor", AMO_F5_XOR, 3'b010, 32'h114, 32'hFF00FF00, 32'hF0F0F0F0, 1'b0, 32'h0FF00FF0, 5, 4);

    run_amo("fault_misalign", AMO_F5_ADD, 3'b010, 32'h102, 32'd1, 32'd0, 1'b1, 32'd0, 2, 1);
    run_amo("fault_funct5",   5'b10000,   3'b010, 32'h118, 32'd1, 32'd0, 1'b1, 32'd0, 2, 1);
    run_amo("fault_funct3",   AMO_F5_ADD, 3'b000, 32'h118, 32'd1, 32'd0, 1'b1, 32'd0, 2, 1);

    // Reset while the read is outstanding; its data then arrives late.
    rv_lat = 3;
    mem[10'h080] = 32'h00000055;
    exp_addr = 32'h200;
    wait_cnt = 0;
    @(negedge clk);
    amo_start  = 1'b1;
    amo_funct5 = AMO_F5_ADD;
    amo_funct3 = 3'b010;
    amo_addr   = 32'h200;
    amo_rs2    = 32'd1;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst       = 1'b1;
    amo_start = 1'b0;
    @(negedge clk);
    #1;
    rst       = 1'b0;
    req_seen  = 1'b0;
    base_wr   = wr_count;
    base_rdwe = rdwe_count;
    base_done = done_count;
    check_reset_outputs("rst_rdwait");
    repeat (10) @(negedge clk);
    #1;
    check("rst_rdwait_late_rvalid_consumed", 32'(rv_cnt), 32'd0);
    check("rst_rdwait_no_req",  32'(req_seen), 32'd0);
    check("rst_rdwait_no_write", 32'(wr_count - base_wr), 32'd0);
    check("rst_rdwait_no_rd_we", 32'(rdwe_count - base_rdwe), 32'd0);
    check("rst_rdwait_no_done", 32'(done_count - base_done), 32'd0);
    check("rst_rdwait_mem", mem[10'h080], 32'h00000055);
    check("rst_rdwait_stall", 32'(stall), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
